// File: rtl/noise_gate_if.sv
// Sample-stream bundle between the effect chain and the noise gate:
// input word and enable in, gated word plus gate status out.
interface noise_gate_if;
    logic [31:0] x;
    logic        en;
    logic [31:0] y;
    logic        gate_open;
    logic [8:0]  gain_o;

    modport master (output x, en, input y, gate_open, gain_o);
    modport slave  (input x, en, output y, gate_open, gain_o);
endinterface

// File: rtl/noise_gate.sv
// Peak-envelope noise gate with attack/hold/release gain ramp, placed in
// front of the tremolo stage; one sample per clk_48 edge.
module noise_gate #(
    parameter logic [23:0] THRESH_OPEN  = 24'd8192,
    parameter logic [23:0] THRESH_CLOSE = 24'd4096,
    parameter int          DECAY_SHIFT  = 4,
    parameter int          ATTACK_STEP  = 64,
    parameter int          HOLD_SAMPLES = 2400,
    parameter int          RELEASE_DIV  = 8
) (
    input  logic         clk_48,
    input  logic         rst_n,
    noise_gate_if.slave  bus
);
    localparam int HW = $clog2(HOLD_SAMPLES + 1);
    localparam int RW = $clog2(RELEASE_DIV + 1);

    typedef enum logic [2:0] {CLOSED, ATTACK, OPEN, HOLD, RELEASE} state_t;

    state_t          state, state_nxt;
    logic [23:0]     env, env_nxt, mag;
    logic [8:0]      gain, gain_nxt;
    logic [9:0]      gain_up;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [RW-1:0]   rel_cnt, rel_nxt;
    logic [31:0]     y_r;
    logic            open_r;
    logic signed [33:0] xs, gs, prod;

    // Full-scale negative input saturates so the magnitude fits 24 bits.
    always_comb begin
        mag = bus.x[23:0];
        if (bus.x[23])
            mag = (bus.x[23:0] == 24'h800000) ? 24'h7FFFFF : (~bus.x[23:0] + 24'd1);
        env_nxt = (mag > env) ? mag : (env - (env >> DECAY_SHIFT));
    end

    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        hold_nxt  = hold_cnt;
        rel_nxt   = rel_cnt;
        gain_up   = {1'b0, gain} + 10'(ATTACK_STEP);
        case (state)
            CLOSED: begin
                gain_nxt = 9'd0;
                if (env >= THRESH_OPEN) state_nxt = ATTACK;
            end
            ATTACK: begin
                if (gain_up >= 10'd256) begin
                    gain_nxt  = 9'd256;
                    state_nxt = OPEN;
                end else begin
                    gain_nxt = gain_up[8:0];
                end
            end
            OPEN: begin
                gain_nxt = 9'd256;
                if (env < THRESH_CLOSE) begin
                    state_nxt = HOLD;
                    hold_nxt  = '0;
                end
            end
            HOLD: begin
                gain_nxt = 9'd256;
                hold_nxt = hold_cnt + 1'b1;
                if (env >= THRESH_OPEN) begin
                    state_nxt = OPEN;
                    hold_nxt  = '0;
                end else if (hold_cnt == HW'(HOLD_SAMPLES - 1)) begin
                    state_nxt = RELEASE;
                    rel_nxt   = '0;
                end
            end
            RELEASE: begin
                // A retrigger keeps the current gain so the ramp turns around without a step.
                if (env >= THRESH_OPEN) begin
                    state_nxt = ATTACK;
                end else if (rel_cnt == RW'(RELEASE_DIV - 1)) begin
                    rel_nxt = '0;
                    if (gain <= 9'd1) begin
                        gain_nxt  = 9'd0;
                        state_nxt = CLOSED;
                    end else begin
                        gain_nxt = gain - 9'd1;
                    end
                end else begin
                    rel_nxt = rel_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = CLOSED;
                gain_nxt  = 9'd0;
            end
        endcase
    end

    // Product uses the pre-update gain; gain <= 256 keeps it within 32 bits.
    assign xs   = {{10{bus.x[23]}}, bus.x[23:0]};
    assign gs   = {25'd0, gain};
    assign prod = xs * gs;

    always_ff @(posedge clk_48) begin
        if (!rst_n) begin
            state    <= CLOSED;
            env      <= '0;
            gain     <= '0;
            hold_cnt <= '0;
            rel_cnt  <= '0;
            y_r      <= '0;
            open_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            env      <= env_nxt;
            gain     <= gain_nxt;
            hold_cnt <= hold_nxt;
            rel_cnt  <= rel_nxt;
            y_r      <= bus.en ? {8'h00, prod[31:8]} : bus.x;
            open_r   <= (state_nxt != CLOSED);
        end
    end

    assign bus.y         = y_r;
    assign bus.gate_open = open_r;
    assign bus.gain_o    = gain;
endmodule

// File: tb/tb_noise_gate.sv
// Scoreboard bench for noise_gate: a behavioural model pushes the expected
// output for every driven sample; results are popped one edge later.
module tb_noise_gate;
    localparam int HOLD = 16;
    localparam int RDIV = 2;
    localparam int STEP = 64;
    localparam int DSH  = 4;
    localparam int T_OPEN = 8192, T_CLOSE = 4096;
    localparam int S_CL = 0, S_AT = 1, S_OP = 2, S_HO = 3, S_RE = 4;

    logic clk_48 = 1'b0;
    logic rst_n  = 1'b0;
    noise_gate_if bus ();

    noise_gate #(.HOLD_SAMPLES(HOLD), .RELEASE_DIV(RDIV), .ATTACK_STEP(STEP),
                 .DECAY_SHIFT(DSH)) dut (.clk_48(clk_48), .rst_n(rst_n), .bus(bus));

    always #5 clk_48 = ~clk_48;

    typedef struct { logic [31:0] y; logic go; logic [8:0] gain; } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_err = 0;
    int m_env = 0, m_gain = 0, m_hold = 0, m_rel = 0, m_st = S_CL;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic [31:0] xv, input logic e, input logic rv);
        exp_t ex;
        logic signed [23:0] t;
        int sx, a, env_old;
        longint p;
        logic [63:0] pv;
        if (!rv) begin
            m_env = 0; m_gain = 0; m_hold = 0; m_rel = 0; m_st = S_CL;
            ex.y = '0;
        end else begin
            t  = xv[23:0];
            sx = t;
            p  = longint'(sx) * longint'(m_gain);
            pv = p >>> 8;
            ex.y = e ? {8'h00, pv[23:0]} : xv;
            env_old = m_env;
            if (m_st == S_CL) begin
                m_gain = 0;
                if (env_old >= T_OPEN) m_st = S_AT;
            end else if (m_st == S_AT) begin
                m_gain = m_gain + STEP;
                if (m_gain >= 256) begin m_gain = 256; m_st = S_OP; end
            end else if (m_st == S_OP) begin
                if (env_old < T_CLOSE) begin m_st = S_HO; m_hold = 0; end
            end else if (m_st == S_HO) begin
                if (env_old >= T_OPEN) begin m_st = S_OP; m_hold = 0; end
                else if (m_hold == HOLD - 1) begin m_st = S_RE; m_rel = 0; m_hold++; end
                else m_hold++;
            end else begin
                if (env_old >= T_OPEN) m_st = S_AT;
                else begin
                    m_rel++;
                    if (m_rel == RDIV) begin
                        m_rel = 0;
                        m_gain--;
                        if (m_gain == 0) m_st = S_CL;
                    end
                end
            end
            a = (sx < 0) ? ((sx == -8388608) ? 8388607 : -sx) : sx;
            m_env = (a > env_old) ? a : env_old - (env_old >> DSH);
        end
        ex.go   = (m_st != S_CL);
        ex.gain = m_gain[8:0];
        sb.push_back(ex);
    endtask

    task automatic cyc(input logic [31:0] xv, input logic e, input logic rv);
        exp_t ex;
        bus.x = xv; bus.en = e; rst_n = rv;
        model_step(xv, e, rv);
        @(posedge clk_48);
        #1;
        ex = sb.pop_front();
        chk("y", bus.y, ex.y);
        chk("gate_open", {31'd0, bus.gate_open}, {31'd0, ex.go});
        chk("gain_o", {23'd0, bus.gain_o}, {23'd0, ex.gain});
    endtask

    initial begin
        int t_a, t_b, k;
        bus.x = '0; bus.en = 1'b1;
        #2;
        // 1: reset then small signal never opens the gate
        cyc(32'h0, 1'b1, 1'b0);
        cyc(32'h0, 1'b1, 1'b0);
        chk("rst_y", bus.y, 32'h0);
        chk("rst_gain", {23'd0, bus.gain_o}, 32'd0);
        for (int i = 0; i < 100; i++) cyc(32'h00000100, 1'b1, 1'b1);
        chk("t1_y", bus.y, 32'h0);
        chk("t1_go", {31'd0, bus.gate_open}, 32'd0);
        chk("t1_gain", {23'd0, bus.gain_o}, 32'd0);

        // 2: attack ramp
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t2_go_e1", {31'd0, bus.gate_open}, 32'd0);
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t2_go_e2", {31'd0, bus.gate_open}, 32'd1);
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t2_g64", {23'd0, bus.gain_o}, 32'd64);
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t2_g128", {23'd0, bus.gain_o}, 32'd128);
        chk("t2_y4096", bus.y, 32'd4096);
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t2_y8192", bus.y, 32'd8192);
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t2_g256", {23'd0, bus.gain_o}, 32'd256);
        chk("t2_y12288", bus.y, 32'd12288);
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t2_y16384", bus.y, 32'd16384);
        for (int i = 0; i < 5; i++) cyc(32'd16384, 1'b1, 1'b1);

        // 3: decay, hold, release to closed
        t_a = -1; t_b = -1;
        for (int i = 0; i < 800 && t_b < 0; i++) begin
            cyc(32'h0, 1'b1, 1'b1);
            if (t_a < 0 && bus.gain_o == 9'd255) t_a = i;
            if (t_a >= 0 && bus.gain_o == 9'd0) begin
                t_b = i;
                chk("t3_go_at_zero", {31'd0, bus.gate_open}, 32'd0);
            end
        end
        chk("t3_release_span", t_b - t_a, 32'd510);

        // 4: retrigger in HOLD, then in RELEASE at gain 100
        for (int i = 0; i < 8; i++) cyc(32'd16384, 1'b1, 1'b1);
        k = 0;
        while (!(m_st == S_HO && m_hold == 10) && k < 200) begin cyc(32'h0, 1'b1, 1'b1); k++; end
        chk("t4_hold_reached", {31'd0, (k < 200)}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(32'd16384, 1'b1, 1'b1);
            chk("t4_hold_gain", {23'd0, bus.gain_o}, 32'd256);
        end
        k = 0;
        while (!(m_st == S_RE && m_gain == 100 && m_rel == 0) && k < 1000) begin
            cyc(32'h0, 1'b1, 1'b1); k++;
        end
        chk("t4_rel_reached", {31'd0, (k < 1000)}, 32'd1);
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t4_g100a", {23'd0, bus.gain_o}, 32'd100);
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t4_g100b", {23'd0, bus.gain_o}, 32'd100);
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t4_g164", {23'd0, bus.gain_o}, 32'd164);
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t4_g228", {23'd0, bus.gain_o}, 32'd228);
        cyc(32'd16384, 1'b1, 1'b1);
        chk("t4_g256", {23'd0, bus.gain_o}, 32'd256);

        // 5: full-scale negative passes unchanged at unity gain
        cyc(32'h00800000, 1'b1, 1'b1);
        chk("t5_y", bus.y, 32'h00800000);
        cyc(32'h00800000, 1'b1, 1'b1);
        cyc(32'h00800000, 1'b1, 1'b1);
        chk("t5_open", {31'd0, bus.gate_open}, 32'd1);

        // 6: bypass, then reset during release
        cyc(32'hDEADBEEF, 1'b0, 1'b1);
        chk("t6_bypass", bus.y, 32'hDEADBEEF);
        k = 0;
        while (!(m_st == S_RE && m_gain < 250) && k < 500) begin cyc(32'h0, 1'b1, 1'b1); k++; end
        chk("t6_rel_reached", {31'd0, (k < 500)}, 32'd1);
        cyc(32'h0, 1'b1, 1'b0);
        chk("t6_rst_y", bus.y, 32'h0);
        chk("t6_rst_gain", {23'd0, bus.gain_o}, 32'd0);
        chk("t6_rst_go", {31'd0, bus.gate_open}, 32'd0);
        for (int i = 0; i < 4; i++) cyc(32'd100, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
